// File: rtl/psum_acc_buf.sv
// Partial-sum accumulation buffer: lane-parallel accumulate into a wrapping entry array,
// then drain requantized (optionally 2:1 max-pooled) words over a valid/ready port.
module psum_acc_buf #(
    parameter int LANES = 8,
    parameter int PIN_W = 22,
    parameter int ACC_W = 24,
    parameter int DEPTH = 32,
    parameter int SHIFT = 7,
    parameter int OUT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       first,
    input  logic                       last,
    input  logic [LANES*PIN_W-1:0]     psumIn,
    input  logic [$clog2(DEPTH)-1:0]   headAddress,
    input  logic [LANES-1:0]           lane_mask,
    input  logic                       pool_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*OUT_W-1:0]     out_data
);

    localparam int AW     = $clog2(DEPTH);
    localparam int NWORDS = DEPTH / LANES;
    localparam int PW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int HALF   = LANES / 2;
    localparam int WW     = ACC_W + OUT_W;

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t                   state_q;
    logic [PW-1:0]            ptr_q;
    logic                     pool_q;
    logic signed [ACC_W-1:0]  acc_q [DEPTH];

    logic [AW-1:0]            lane_addr [LANES];
    logic signed [ACC_W-1:0]  lane_sum  [LANES];
    logic [OUT_W-1:0]         r         [LANES];
    logic                     accepted;
    logic                     last_word;

    // Negative entries clamp to 0, large ones saturate to the top output code.
    function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] v);
        logic [WW-1:0] sh;
        if (v[ACC_W-1]) return '0;
        sh = {{OUT_W{1'b0}}, v} >> SHIFT;
        if (sh > WW'({OUT_W{1'b1}})) return '1;
        return sh[OUT_W-1:0];
    endfunction

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DRAIN);
    assign accepted  = in_valid && in_ready;
    assign last_word = (ptr_q == PW'(NWORDS - 1));

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_addr[k] = headAddress + AW'(k);
            lane_sum[k]  = (first ? '0 : acc_q[lane_addr[k]])
                         + ACC_W'(signed'(psumIn[k*PIN_W +: PIN_W]));
        end
    end

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            r[j] = requant(acc_q[AW'(int'(ptr_q) * LANES + j)]);
        end
    end

    always_comb begin
        out_data = '0;
        if (state_q == DRAIN) begin
            if (pool_q) begin
                for (int j = 0; j < HALF; j++) begin
                    out_data[j*OUT_W +: OUT_W] = (r[2*j] > r[2*j+1]) ? r[2*j] : r[2*j+1];
                end
            end else begin
                for (int j = 0; j < LANES; j++) begin
                    out_data[j*OUT_W +: OUT_W] = r[j];
                end
            end
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every lane sees pre-edge entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            ptr_q   <= '0;
            pool_q  <= 1'b0;
            // NOTE: the entry array is reset explicitly; a pass may legitimately start without first.
            for (int i = 0; i < DEPTH; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accepted) begin
                        for (int k = 0; k < LANES; k++) begin
                            if (lane_mask[k]) acc_q[lane_addr[k]] <= lane_sum[k];
                        end
                        if (last) begin
                            state_q <= DRAIN;
                            ptr_q   <= '0;
                            pool_q  <= pool_en;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (last_word) state_q <= ACCUM;
                        else           ptr_q   <= ptr_q + PW'(1);
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_acc_buf.sv
// Self-checking bench for psum_acc_buf: hand-derived vector table, stall/reset corner
// sequences, and randomized passes checked against an array-based reference model.
module tb_psum_acc_buf;

    localparam int LANES = 8;
    localparam int PIN_W = 22;
    localparam int ACC_W = 24;
    localparam int DEPTH = 32;
    localparam int SHIFT = 7;
    localparam int OUT_W = 8;
    localparam int NW    = DEPTH / LANES;
    localparam int AW    = 5;

    logic                     clk;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic                     first;
    logic                     last;
    logic [LANES*PIN_W-1:0]   psumIn;
    logic [AW-1:0]            headAddress;
    logic [LANES-1:0]         lane_mask;
    logic                     pool_en;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*OUT_W-1:0]   out_data;

    psum_acc_buf #(
        .LANES(LANES), .PIN_W(PIN_W), .ACC_W(ACC_W),
        .DEPTH(DEPTH), .SHIFT(SHIFT), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .first(first), .last(last), .psumIn(psumIn), .headAddress(headAddress),
        .lane_mask(lane_mask), .pool_en(pool_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: plain signed integers per entry, wrapped to ACC_W bits on each write.
    int model [DEPTH];
    bit pool_m;

    typedef struct {
        bit                     rst_before;
        bit                     f;
        bit                     l;
        logic [AW-1:0]          head;
        logic [LANES-1:0]       mask;
        logic [LANES*PIN_W-1:0] ps;
        bit                     pool;
        logic [NW*64-1:0]       exp;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LANES*PIN_W-1:0] pk8(input int a, b, c, d, e, f, g, h);
        int v [LANES];
        logic [LANES*PIN_W-1:0] res;
        v = '{a, b, c, d, e, f, g, h};
        for (int k = 0; k < LANES; k++) res[k*PIN_W +: PIN_W] = PIN_W'(v[k]);
        return res;
    endfunction

    function automatic logic [LANES*PIN_W-1:0] pk_all(input int v);
        return pk8(v, v, v, v, v, v, v, v);
    endfunction

    function automatic logic [NW*64-1:0] ew(input logic [63:0] w0, w1, w2, w3);
        return {w3, w2, w1, w0};
    endfunction

    function automatic vec_t mkv(input bit rb, f, l, input int head, input logic [7:0] mask,
                                 input logic [LANES*PIN_W-1:0] ps, input bit pool,
                                 input logic [NW*64-1:0] exp);
        vec_t v;
        v.rst_before = rb; v.f = f; v.l = l; v.head = AW'(head); v.mask = mask;
        v.ps = ps; v.pool = pool; v.exp = exp;
        return v;
    endfunction

    function automatic int wrap_acc(input int v);
        int m;
        m = v % (1 << ACC_W);
        if (m < 0) m += (1 << ACC_W);
        if (m >= (1 << (ACC_W - 1))) m -= (1 << ACC_W);
        return m;
    endfunction

    function automatic int rq(input int v);
        int q;
        if (v < 0) return 0;
        q = v / (1 << SHIFT);
        return (q > 255) ? 255 : q;
    endfunction

    function automatic logic [NW*64-1:0] model_exp();
        logic [NW*64-1:0] res;
        int rr [LANES];
        res = '0;
        for (int w = 0; w < NW; w++) begin
            for (int j = 0; j < LANES; j++) rr[j] = rq(model[w*LANES + j]);
            for (int j = 0; j < LANES; j++) begin
                if (!pool_m)             res[w*64 + j*8 +: 8] = 8'(rr[j]);
                else if (j < LANES / 2)  res[w*64 + j*8 +: 8] = 8'((rr[2*j] > rr[2*j+1]) ? rr[2*j] : rr[2*j+1]);
            end
        end
        return res;
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; first = 1'b0; last = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 0;
        pool_m = 1'b0;
    endtask

    task automatic send_beat(input bit f, l, input logic [AW-1:0] head, input logic [LANES-1:0] mask,
                             input logic [LANES*PIN_W-1:0] ps, input bit pool);
        logic [AW-1:0] a;
        int lane;
        in_valid = 1'b1; first = f; last = l; headAddress = head;
        lane_mask = mask; psumIn = ps; pool_en = pool;
        check("in_ready_accum", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; first = 1'b0; last = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (mask[k]) begin
                a = head + AW'(k);
                lane = int'(signed'(ps[k*PIN_W +: PIN_W]));
                model[a] = wrap_acc((f ? 0 : model[a]) + lane);
            end
        end
        if (l) pool_m = pool;
        check("out_valid_after_beat", 64'(out_valid), 64'(l));
    endtask

    task automatic drain(input logic [NW*64-1:0] exp, input string tag, input int max_stall);
        int stall;
        for (int w = 0; w < NW; w++) begin
            stall = (max_stall > 0) ? $urandom_range(0, max_stall) : 0;
            for (int s = 0; s < stall; s++) begin
                check($sformatf("%s_w%0d_hold", tag, w), out_data, exp[w*64 +: 64]);
                @(posedge clk); #1;
            end
            check($sformatf("%s_w%0d_valid", tag, w), 64'(out_valid), 64'd1);
            check($sformatf("%s_w%0d_inrdy", tag, w), 64'(in_ready), 64'd0);
            check($sformatf("%s_w%0d_data", tag, w), out_data, exp[w*64 +: 64]);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        check($sformatf("%s_end_valid", tag), 64'(out_valid), 64'd0);
        check($sformatf("%s_end_inrdy", tag), 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; first = 1'b0; last = 1'b0; psumIn = '0;
        headAddress = '0; lane_mask = '0; pool_en = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_data", out_data, 64'd0);

        // Hand-derived vectors; expectations only on last beats.
        tbl.push_back(mkv(1, 1, 1, 0, 8'hFF, pk_all(1024), 0,
                          ew(64'h0808080808080808, 0, 0, 0)));
        tbl.push_back(mkv(1, 1, 1, 30, 8'hFF, pk_all(128), 0,
                          ew(64'h0000010101010101, 0, 0, 64'h0101000000000000)));
        tbl.push_back(mkv(1, 1, 0, 0, 8'h03, pk8(-5, -200, 999999, 999999, 999999, 999999, 999999, 999999), 0, '0));
        tbl.push_back(mkv(0, 0, 1, 0, 8'h01, pk8(1000, 12345, 5, 5, 5, 5, 5, 5), 0,
                          ew(64'h07, 0, 0, 0)));
        tbl.push_back(mkv(1, 1, 0, 8, 8'h01, pk_all(2097088), 0, '0));
        tbl.push_back(mkv(0, 0, 0, 8, 8'h01, pk_all(2097088), 0, '0));
        tbl.push_back(mkv(0, 0, 0, 8, 8'h01, pk_all(2097088), 0, '0));
        tbl.push_back(mkv(0, 0, 1, 8, 8'h01, pk_all(2097088), 0,
                          ew(0, 64'hFF, 0, 0)));
        tbl.push_back(mkv(1, 1, 1, 0, 8'hFF, pk8(511, 1152, -7, 130, 896, 1000, 25600, 600), 1,
                          ew(64'h00000000C8070109, 0, 0, 0)));
        tbl.push_back(mkv(0, 1, 1, 4, 8'hF0, pk_all(256), 0,
                          ew(64'h04C8070701000903, 64'h0000000002020202, 0, 0)));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst_before) do_reset();
            send_beat(tbl[i].f, tbl[i].l, tbl[i].head, tbl[i].mask, tbl[i].ps, tbl[i].pool);
            if (tbl[i].l) drain(tbl[i].exp, $sformatf("vec%0d", i), 0);
        end

        // Stall on word 1, ignored beat during drain, then reset mid-drain.
        do_reset();
        send_beat(1, 1, 8, 8'hFF, pk8(128, 256, 384, 512, 640, 768, 896, 1024), 0);
        in_valid = 1'b1; first = 1'b1; last = 1'b1; headAddress = 8;
        lane_mask = 8'hFF; psumIn = pk_all(-1);
        check("drain_in_ready", 64'(in_ready), 64'd0);
        check("stall_w0_data", out_data, 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0; first = 1'b0; last = 1'b0;
        for (int s = 0; s < 5; s++) begin
            check("stall_w1_valid", 64'(out_valid), 64'd1);
            check("stall_w1_data", out_data, 64'h0807060504030201);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("w2_valid_before_rst", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 0;
        pool_m = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_data", out_data, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_valid", 64'(out_valid), 64'd0);
        send_beat(0, 1, 0, 8'h00, pk_all(77), 0);
        drain('0, "cleared", 0);

        // Randomized passes against the reference model.
        do_reset();
        for (int p = 0; p < 40; p++) begin
            int nb;
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                logic [LANES*PIN_W-1:0] ps;
                logic [LANES-1:0] mask;
                for (int k = 0; k < LANES; k++) begin
                    if ($urandom_range(0, 3) == 0) ps[k*PIN_W +: PIN_W] = PIN_W'($urandom);
                    else ps[k*PIN_W +: PIN_W] = PIN_W'($urandom_range(0, 40000) - 5000);
                end
                mask = ($urandom_range(0, 2) == 0) ? LANES'($urandom) : '1;
                send_beat((b == 0) && ($urandom_range(0, 3) != 0), b == nb - 1,
                          AW'($urandom), mask, ps, 1'($urandom));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #0;
            end
            drain(model_exp(), $sformatf("rand%0d", p), 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psum_acc_buf.md
PSUM_ACC_BUF -- requirements
Module: psum_acc_buf

Interface
REQ-001 Parameter LANES, default 8, meaning accumulation lanes per beat; even, >=2.
REQ-002 Parameter PIN_W, default 22, meaning signed width of each incoming partial sum.
REQ-003 Parameter ACC_W, default 24, meaning signed accumulator width; ACC_W >= PIN_W.
REQ-004 Parameter DEPTH, default 32, meaning accumulator entries; power of 2 and a multiple of LANES.
REQ-005 Parameter SHIFT, default 7, meaning requantization right-shift applied before output.
REQ-006 Parameter OUT_W, default 8, meaning unsigned width of each output element.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 in_valid  input  1  psum beat offered.
REQ-010 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-011 first  input  1  beat overwrites target entries instead of adding.
REQ-012 last  input  1  final beat of the pass; starts drain.
REQ-013 psumIn  input  LANES*PIN_W  lane k at bits [k*PIN_W +: PIN_W], two's complement.
REQ-014 headAddress  input  log2(DEPTH)  entry targeted by lane 0.
REQ-015 lane_mask  input  LANES  lane k writes only when bit k = 1.
REQ-016 pool_en  input  1  sampled with the last beat; selects 2:1 max-pool drain.
REQ-017 out_valid  output  1  output word valid.
REQ-018 out_ready  input  1  output word consumed when out_valid && out_ready.
REQ-019 out_data  output  LANES*OUT_W  element j at bits [j*OUT_W +: OUT_W].

Function
REQ-020 Two states: ACCUM (in_ready = 1, out_valid = 0) and DRAIN (in_ready = 0).
REQ-021 Accepted beat, lane k with mask bit set: entry (headAddress+k) mod DEPTH <= (first ? 0 : entry) + sign-extended lane k.
REQ-022 Address wrap-around past DEPTH-1 to entry 0 is required behaviour, not an error.
REQ-023 Accumulation is modulo 2^ACC_W (wrap, no saturation).
REQ-024 Masked-off lanes leave their entries unchanged, including when first = 1.
REQ-025 Accepted beat with last = 1 is accumulated, latches pool_en into pool_q, clears the drain pointer to 0, and moves to DRAIN.
REQ-026 out_valid = 1 the cycle after the last beat is accepted (latency 1); out_data reflects that beat's accumulation.
REQ-027 DRAIN emits DEPTH/LANES words; word w covers entries w*LANES .. w*LANES+LANES-1.
REQ-028 Per entry: r = (v < 0) ? 0 : min(v >>> SHIFT, 2^OUT_W - 1).
REQ-029 pool_q = 0: element j = r(entry w*LANES+j).
REQ-030 pool_q = 1: element j (j < LANES/2) = max(r(2j), r(2j+1)) within the word; elements >= LANES/2 = 0.
REQ-031 out_data and out_valid hold stable while out_valid && !out_ready.
REQ-032 On handshake the pointer advances; after the final word is consumed, state returns to ACCUM next cycle with in_ready = 1.
REQ-033 in_valid during DRAIN is ignored; no entry changes.
REQ-034 first and last on the same beat: overwrite, then drain.
REQ-035 Entries are not cleared by drain; the next pass clears with first.

Reset
REQ-036 rst, in any state, drives next cycle: state ACCUM, all entries 0, drain pointer 0, pool_q 0, out_valid 0, out_data 0, in_ready 1.
REQ-037 rst asserted mid-DRAIN abandons remaining words; no further out_valid until a new last beat.

Verification
REQ-038 LANES=8: beat first=1, headAddress=0, all lanes 0x000400, last=1 -> next cycle out_valid, word 0 elements all 8 (0x400>>7); 4 words total.
REQ-039 headAddress=30, first=1, lanes 0..7 = 128 each -> entries 30,31,0..5 = 128; drained words show element value 1 at those positions, 0 elsewhere.
REQ-040 Lane value -5 then +1000 on same entry over two beats (second last=1) -> drained element 7 (995>>7); single beat -200 -> element 0.
REQ-041 Entry value 0x7FFF00 -> element saturates to 255.
REQ-042 pool_en=1, word 0 results r = {3,9,0,1,7,7,200,4} -> elements {9,1,7,200,0,0,0,0}.
REQ-043 Hold out_ready=0 for 5 cycles on word 1 -> out_data stable; rst mid-DRAIN -> out_valid 0 next cycle, in_ready 1, all entries 0.
